// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM time-base and compare stages.
package pwm_pkg;

  localparam int unsigned PwmWidth    = 16;
  localparam int unsigned PwmPscWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: tick is high on the clock where the counter reaches lim.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PSC_WIDTH = PwmPscWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [PSC_WIDTH-1:0] lim,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;

  assign tick = (psc_cnt_q == lim);

  always_comb begin
    psc_cnt_d = psc_cnt_q + PSC_WIDTH'(1);
    if (clear || tick) begin
      psc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// PWM time base: prescaled counter, shadowed PERIOD/CCR/DELAY, run FSM with one-shot
// and forced update. All outputs are registered.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH     = PwmWidth,
  parameter int unsigned PSC_WIDTH = PwmPscWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PSC_WIDTH-1:0] psc,
  input  logic [WIDTH-1:0]     period_in,
  input  logic [WIDTH-1:0]     ccr_in,
  input  logic [WIDTH-1:0]     delay_in,
  input  logic                 wr_period,
  input  logic                 wr_ccr,
  input  logic                 wr_delay,
  input  logic                 preload_en,
  input  logic                 one_shot,
  input  logic                 force_update,
  output logic [WIDTH-1:0]     cnt,
  output logic [WIDTH-1:0]     period,
  output logic [WIDTH-1:0]     ccr,
  output logic [WIDTH-1:0]     delay,
  output logic                 cnt_en,
  output logic                 update_evt
);

  pwm_state_e state_q, state_d;

  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     period_q, period_d;
  logic [WIDTH-1:0]     ccr_q, ccr_d;
  logic [WIDTH-1:0]     delay_q, delay_d;
  logic [WIDTH-1:0]     pend_period_q, pend_period_d;
  logic [WIDTH-1:0]     pend_ccr_q, pend_ccr_d;
  logic [WIDTH-1:0]     pend_delay_q, pend_delay_d;
  logic [PSC_WIDTH-1:0] psc_lim_q, psc_lim_d;
  logic                 cnt_en_q, cnt_en_d;
  logic                 upd_evt_q, upd_evt_d;

  logic             tick;
  logic             upd;
  logic             psc_clear;
  logic [WIDTH-1:0] period_last;

  // Last count value of a period; guarded so PERIOD==0 never underflows.
  assign period_last = (period_q != '0) ? (period_q - WIDTH'(1)) : '0;

  // Run FSM and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upd     = 1'b0;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StRun;
          upd     = 1'b1;
        end
        StRun: begin
          if (force_update) begin
            upd = 1'b1;
          end else if (tick && (period_q != '0)) begin
            // >= so that an immediate period reduction below cnt wraps at once.
            if (cnt_q >= period_last) begin
              upd = 1'b1;
              if (one_shot) begin
                state_d = StDone;
              end
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
        end
        StDone: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
    if (upd) begin
      cnt_d = '0;
    end
  end

  // Prescaler is held at zero outside RUN and restarted on every update event.
  assign psc_clear = (state_d != StRun) || upd;

  pwm_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(psc_clear),
    .lim  (psc_lim_q),
    .tick (tick)
  );

  // Shadow registers: an update event takes the pending value, including one
  // written on the same edge.
  always_comb begin
    pend_period_d = wr_period ? period_in : pend_period_q;
    pend_ccr_d    = wr_ccr    ? ccr_in    : pend_ccr_q;
    pend_delay_d  = wr_delay  ? delay_in  : pend_delay_q;

    period_d  = period_q;
    ccr_d     = ccr_q;
    delay_d   = delay_q;
    psc_lim_d = psc_lim_q;

    if (upd) begin
      period_d  = pend_period_d;
      ccr_d     = pend_ccr_d;
      delay_d   = pend_delay_d;
      psc_lim_d = psc;
    end else if (!preload_en) begin
      if (wr_period) period_d = period_in;
      if (wr_ccr)    ccr_d    = ccr_in;
      if (wr_delay)  delay_d  = delay_in;
    end

    cnt_en_d  = (state_d == StRun);
    upd_evt_d = upd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      period_q      <= '0;
      ccr_q         <= '0;
      delay_q       <= '0;
      pend_period_q <= '0;
      pend_ccr_q    <= '0;
      pend_delay_q  <= '0;
      psc_lim_q     <= '0;
      cnt_en_q      <= 1'b0;
      upd_evt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      ccr_q         <= ccr_d;
      delay_q       <= delay_d;
      pend_period_q <= pend_period_d;
      pend_ccr_q    <= pend_ccr_d;
      pend_delay_q  <= pend_delay_d;
      psc_lim_q     <= psc_lim_d;
      cnt_en_q      <= cnt_en_d;
      upd_evt_q     <= upd_evt_d;
    end
  end

  assign cnt        = cnt_q;
  assign period     = period_q;
  assign ccr        = ccr_q;
  assign delay      = delay_q;
  assign cnt_en     = cnt_en_q;
  assign update_evt = upd_evt_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed testbench for pwm_timebase with hand-computed expectations.
module tb_pwm_timebase;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] psc;
  logic [15:0] period_in, ccr_in, delay_in;
  logic        wr_period, wr_ccr, wr_delay;
  logic        preload_en, one_shot, force_update;
  logic [15:0] cnt, period, ccr, delay;
  logic        cnt_en, update_evt;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] e_cnt, e_per;
  logic        e_evt, e_en;

  pwm_timebase #(
    .WIDTH    (16),
    .PSC_WIDTH(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .psc         (psc),
    .period_in   (period_in),
    .ccr_in      (ccr_in),
    .delay_in    (delay_in),
    .wr_period   (wr_period),
    .wr_ccr      (wr_ccr),
    .wr_delay    (wr_delay),
    .preload_en  (preload_en),
    .one_shot    (one_shot),
    .force_update(force_update),
    .cnt         (cnt),
    .period      (period),
    .ccr         (ccr),
    .delay       (delay),
    .cnt_en      (cnt_en),
    .update_evt  (update_evt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] p, input logic [15:0] c, input logic [15:0] d,
                      input logic pre);
    preload_en = pre;
    period_in  = p;
    ccr_in     = c;
    delay_in   = d;
    wr_period  = 1'b1;
    wr_ccr     = 1'b1;
    wr_delay   = 1'b1;
    step();
    wr_period  = 1'b0;
    wr_ccr     = 1'b0;
    wr_delay   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; psc = '0;
    period_in = '0; ccr_in = '0; delay_in = '0;
    wr_period = 1'b0; wr_ccr = 1'b0; wr_delay = 1'b0;
    preload_en = 1'b0; one_shot = 1'b0; force_update = 1'b0;
    step(); step();
    n_cmp++;
    if ({cnt, period, ccr, delay, cnt_en, update_evt} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got cnt=%0d per=%0d ccr=%0d dly=%0d en=%0b evt=%0b, want all 0",
               cnt, period, ccr, delay, cnt_en, update_evt);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({cnt, period, cnt_en, update_evt} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_idle: got cnt=%0d per=%0d en=%0b evt=%0b, want all 0",
               cnt, period, cnt_en, update_evt);
    end
  endtask

  task automatic test_basic();
    en = 1'b0; psc = 16'd0;
    load(16'd10, 16'd4, 16'd2, 1'b1);
    n_cmp++;
    if ({period, ccr, delay} !== 48'd0) begin
      n_err++;
      $display("FAIL basic_preload_idle: got %0d/%0d/%0d want 0/0/0", period, ccr, delay);
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (cnt !== 16'd0 || update_evt !== 1'b1 || cnt_en !== 1'b1) begin
      n_err++;
      $display("FAIL basic_start: got cnt=%0d evt=%0b en=%0b want 0/1/1", cnt, update_evt, cnt_en);
    end
    n_cmp++;
    if (period !== 16'd10 || ccr !== 16'd4 || delay !== 16'd2) begin
      n_err++;
      $display("FAIL basic_active: got %0d/%0d/%0d want 10/4/2", period, ccr, delay);
    end
    for (int k = 1; k < 30; k++) begin
      step();
      e_cnt = 16'(k % 10);
      e_evt = (k % 10 == 0);
      n_cmp++;
      if (cnt !== e_cnt || update_evt !== e_evt || cnt_en !== 1'b1) begin
        n_err++;
        $display("FAIL basic_run k=%0d: got cnt=%0d evt=%0b en=%0b want %0d/%0b/1",
                 k, cnt, update_evt, cnt_en, e_cnt, e_evt);
      end
    end
  endtask

  task automatic test_prescaler();
    en = 1'b0;
    step();
    psc = 16'd2;
    load(16'd4, 16'd1, 16'd0, 1'b0);
    en = 1'b1;
    step();
    n_cmp++;
    if (update_evt !== 1'b1 || cnt !== 16'd0) begin
      n_err++;
      $display("FAIL psc_start: got cnt=%0d evt=%0b want 0/1", cnt, update_evt);
    end
    for (int k = 1; k <= 28; k++) begin
      step();
      if (k <= 24) begin
        e_cnt = 16'((k / 3) % 4);
        e_evt = (k % 12 == 0);
      end else begin
        e_cnt = 16'((k - 24) % 4);
        e_evt = ((k - 24) % 4 == 0);
      end
      n_cmp++;
      if (cnt !== e_cnt || update_evt !== e_evt) begin
        n_err++;
        $display("FAIL psc_run k=%0d: got cnt=%0d evt=%0b want %0d/%0b",
                 k, cnt, update_evt, e_cnt, e_evt);
      end
      if (k == 13) psc = 16'd0;
    end
  endtask

  task automatic test_preload();
    en = 1'b0;
    step();
    load(16'd10, 16'd4, 16'd2, 1'b0);
    en = 1'b1;
    step();
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k < 10) begin
        e_cnt = 16'(k); e_evt = 1'b0; e_per = 16'd10;
      end else if (k < 20) begin
        e_cnt = 16'((k - 10) % 5); e_evt = ((k - 10) % 5 == 0); e_per = 16'd5;
      end else if (k < 28) begin
        e_cnt = 16'(k - 20); e_evt = (k == 20); e_per = 16'd10;
      end else if (k == 28) begin
        e_cnt = 16'd8; e_evt = 1'b0; e_per = 16'd5;
      end else begin
        e_cnt = 16'd0; e_evt = 1'b1; e_per = 16'd5;
      end
      n_cmp++;
      if (cnt !== e_cnt || update_evt !== e_evt || period !== e_per) begin
        n_err++;
        $display("FAIL preload k=%0d: got cnt=%0d evt=%0b per=%0d want %0d/%0b/%0d",
                 k, cnt, update_evt, period, e_cnt, e_evt, e_per);
      end
      wr_period  = (k == 3 || k == 15 || k == 27);
      period_in  = (k == 15) ? 16'd10 : 16'd5;
      preload_en = (k != 27);
    end
    wr_period = 1'b0;
  endtask

  task automatic test_one_shot();
    en = 1'b0;
    step();
    load(16'd6, 16'd4, 16'd2, 1'b0);
    one_shot = 1'b1;
    en = 1'b1;
    step();
    n_cmp++;
    if (update_evt !== 1'b1 || cnt_en !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_start: got evt=%0b en=%0b want 1/1", update_evt, cnt_en);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      e_cnt = (k <= 5) ? 16'(k) : 16'd0;
      e_en  = (k <= 5);
      e_evt = (k == 6);
      n_cmp++;
      if (cnt !== e_cnt || cnt_en !== e_en || update_evt !== e_evt) begin
        n_err++;
        $display("FAIL oneshot_run k=%0d: got cnt=%0d en=%0b evt=%0b want %0d/%0b/%0b",
                 k, cnt, cnt_en, update_evt, e_cnt, e_en, e_evt);
      end
    end
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    n_cmp++;
    if (update_evt !== 1'b1 || cnt_en !== 1'b1 || cnt !== 16'd0) begin
      n_err++;
      $display("FAIL oneshot_restart: got evt=%0b en=%0b cnt=%0d want 1/1/0",
               update_evt, cnt_en, cnt);
    end
    step();
    n_cmp++;
    if (cnt !== 16'd1 || cnt_en !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_rerun: got cnt=%0d en=%0b want 1/1", cnt, cnt_en);
    end
    one_shot = 1'b0;
  endtask

  task automatic test_force_update();
    en = 1'b0;
    step();
    load(16'd10, 16'd4, 16'd2, 1'b0);
    en = 1'b1;
    step();
    for (int k = 1; k <= 6; k++) step();
    n_cmp++;
    if (cnt !== 16'd6) begin
      n_err++;
      $display("FAIL force_pre: got cnt=%0d want 6", cnt);
    end
    force_update = 1'b1; wr_ccr = 1'b1; ccr_in = 16'd9; preload_en = 1'b1;
    step();
    force_update = 1'b0; wr_ccr = 1'b0;
    n_cmp++;
    if (cnt !== 16'd0 || update_evt !== 1'b1 || ccr !== 16'd9 || period !== 16'd10) begin
      n_err++;
      $display("FAIL force_evt: got cnt=%0d evt=%0b ccr=%0d per=%0d want 0/1/9/10",
               cnt, update_evt, ccr, period);
    end
    step();
    n_cmp++;
    if (cnt !== 16'd1 || update_evt !== 1'b0) begin
      n_err++;
      $display("FAIL force_after: got cnt=%0d evt=%0b want 1/0", cnt, update_evt);
    end
    en = 1'b0;
    step();
    load(16'd0, 16'd4, 16'd2, 1'b0);
    en = 1'b1;
    step();
    n_cmp++;
    if (update_evt !== 1'b1 || period !== 16'd0) begin
      n_err++;
      $display("FAIL zero_start: got evt=%0b per=%0d want 1/0", update_evt, period);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (cnt !== 16'd0 || update_evt !== 1'b0 || cnt_en !== 1'b1) begin
        n_err++;
        $display("FAIL zero_hold k=%0d: got cnt=%0d evt=%0b en=%0b want 0/0/1",
                 k, cnt, update_evt, cnt_en);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    en = 1'b0;
    step();
    load(16'd10, 16'd4, 16'd2, 1'b0);
    en = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) step();
    n_cmp++;
    if (cnt !== 16'd5) begin
      n_err++;
      $display("FAIL rst_pre: got cnt=%0d want 5", cnt);
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({cnt, period, ccr, delay, cnt_en, update_evt} !== 66'd0) begin
      n_err++;
      $display("FAIL rst_mid: got cnt=%0d per=%0d ccr=%0d dly=%0d en=%0b evt=%0b, want all 0",
               cnt, period, ccr, delay, cnt_en, update_evt);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (update_evt !== 1'b1 || cnt_en !== 1'b1 || {cnt, period, ccr, delay} !== 64'd0) begin
      n_err++;
      $display("FAIL rst_restart: got evt=%0b en=%0b cnt=%0d per=%0d ccr=%0d dly=%0d want 1/1/0/0/0/0",
               update_evt, cnt_en, cnt, period, ccr, delay);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (cnt !== 16'd0 || update_evt !== 1'b0) begin
        n_err++;
        $display("FAIL rst_hold k=%0d: got cnt=%0d evt=%0b want 0/0", k, cnt, update_evt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescaler();
    test_preload();
    test_one_shot();
    test_force_update();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_timebase.md
Name: pwm_timebase

Overview:
Timer/time-base stage that sits directly upstream of the PWM compare stage. It generates the free-running count CNT, the enable qualifier and the active PERIOD/CCR/DELAY values that the compare stage consumes. It provides a prescaler, shadow (preload) registers with update-event transfer, forced update and one-shot mode. All outputs are registered.

Parameters:
WIDTH, 16, width of CNT, PERIOD, CCR, DELAY
PSC_WIDTH, 16, width of prescaler value

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  synchronous reset, active low
EN  input  1  run enable; level
PSC  input  PSC_WIDTH  prescaler; count tick every PSC+1 clocks
PERIOD_IN  input  WIDTH  period write data
CCR_IN  input  WIDTH  compare/duty write data
DELAY_IN  input  WIDTH  phase-delay write data
WR_PERIOD  input  1  write strobe for PERIOD_IN
WR_CCR  input  1  write strobe for CCR_IN
WR_DELAY  input  1  write strobe for DELAY_IN
PRELOAD_EN  input  1  1 = writes take effect at next update event; 0 = immediate
ONE_SHOT  input  1  1 = stop after one full period
FORCE_UPDATE  input  1  single-cycle software update request
CNT  output  WIDTH  current count
PERIOD  output  WIDTH  active period
CCR  output  WIDTH  active compare
DELAY  output  WIDTH  active delay
CNT_EN  output  1  enable for compare stage; 1 only in RUN
UPDATE_EVT  output  1  one-cycle pulse on each update event

Behaviour:
- Reset (RST_N=0 at an edge): all outputs 0. Pending registers 0. Prescaler counter 0. State IDLE. Reset overrides every other input, including mid-run.
- Writes: WR_x=1 captures x_IN into pending_x in every state.
  - PRELOAD_EN=0: the active x is also loaded on the same edge and is visible the next cycle.
  - PRELOAD_EN=1: the active x is loaded only at the next update event.
- Update event: pending PERIOD/CCR/DELAY → active; PSC sampled into the prescaler limit; CNT<=0; prescaler counter<=0; UPDATE_EVT=1 for exactly one cycle, coincident with CNT==0.
- Write coincident with an update event: the newly written x_IN is what reaches the active register.
- Prescaler: psc_cnt counts 0..psc_lim. tick=1 when psc_cnt==psc_lim, then psc_cnt wraps to 0. PSC=0 gives a tick every clock. The sampled psc_lim changes only at update events.
- States:
  - IDLE: CNT=0, CNT_EN=0, psc_cnt=0. EN=1 → RUN and perform an update event on that edge (first UPDATE_EVT, CNT_EN=1 next cycle).
  - RUN: on tick, if PERIOD==0, CNT stays 0 and no event fires. Else if CNT>=PERIOD-1, an update event fires (the wrap). Else CNT<=CNT+1.
  - RUN wrap with ONE_SHOT=1: → DONE instead (still transfers the pending registers and pulses UPDATE_EVT).
  - DONE: CNT=0, CNT_EN=0, no ticks. Exit only via EN=0 → IDLE.
  - Any state with EN=0 → IDLE next edge. Active and pending registers are retained.
- The >= wrap compare makes an immediate PERIOD reduction below the current CNT wrap on the next tick, with no roll through 2^WIDTH.
- FORCE_UPDATE in RUN: update event on that edge regardless of tick; it has priority over tick/increment. Ignored in IDLE/DONE, where the pending registers are still loaded at the next start.
- CNT arithmetic is unsigned WIDTH bits. PERIOD-1 is computed only when PERIOD!=0. CNT never exceeds max(PERIOD-1, 0) except transiently after a non-preloaded PERIOD reduction (at most one tick).
- Latency: EN rise → CNT_EN=1 one cycle later. Wrap condition → UPDATE_EVT/CNT=0 on the next edge.

Decomposition:
- Package pwm_pkg: state enum {IDLE, RUN, DONE}, default WIDTH/PSC_WIDTH constants, shared with the compare stage.
- One sub-module, pwm_prescaler. Inputs: CLK, RST_N, clear, lim. Output: tick.
- Shadow/active register logic and the FSM stay in pwm_timebase.

Test Plan:
1. PSC=0, write PERIOD=10/CCR=4/DELAY=2 (PRELOAD_EN=1), EN=1 → UPDATE_EVT next cycle; CNT 0..9 repeating; UPDATE_EVT every 10 cycles with CNT==0; CNT_EN=1; active regs 10/4/2.
2. PSC=2, PERIOD=4 → CNT steps every 3 clocks; UPDATE_EVT period 12 clocks. Change PSC to 0 mid-period → new rate only after the next UPDATE_EVT.
3. PERIOD=10 running. PRELOAD_EN=1, write PERIOD_IN=5 at CNT=3 → PERIOD stays 10 until wrap, then 5 (CNT 0..4). PRELOAD_EN=0, write 5 at CNT=7 → PERIOD=5 next cycle; CNT wraps to 0 on the next tick.
4. ONE_SHOT=1, PERIOD=6 → one pass CNT 0..5, then DONE: CNT=0, CNT_EN=0, UPDATE_EVT pulse. EN stays 1 → stays DONE. EN 0→1 → restart.
5. FORCE_UPDATE at CNT=6 with WR_CCR=1 (CCR_IN=9) on the same edge → CNT=0, UPDATE_EVT=1, CCR=9 next cycle. Also cover PERIOD=0 → CNT held 0, no UPDATE_EVT.
6. RST_N=0 at CNT=5 during RUN → next cycle all outputs 0, state IDLE. Release with EN=1 → fresh start with pending=0, so PERIOD=0 and CNT holds 0.
